jtkicker_colmix: RTL and testbench

Colour mixer downstream of the scroll tile layer. Each pixel it merges the scroll layer's 4-bit palette output and priority flag with the sprite layer's 4-bit output. It resolves which layer wins, looks the result up in a 32×8 colour PROM (RRRGGGBB) and expands it to 4-bit RGB. Blanking is delayed to match the pipeline, and the block drives the final video outputs of the core.

---
 rtl/jtkicker_colmix.sv | 84 ++++++++
 tb/tb_jtkicker_colmix.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/jtkicker_colmix.sv
// Merges scroll and sprite pixels, looks the winner up in a 32x8 colour PROM and expands it to 4-bit RGB.
// Latency: 2 pxl_cen edges after capture, blanking delayed to match. No backpressure: everything advances only on pxl_cen.
module jtkicker_colmix #(
    parameter int BLANK_DLY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic [3:0] scr_pxl,
    input  logic       scr_prio,
    input  logic [3:0] obj_pxl,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic [4:0] prog_addr,
    input  logic [7:0] prog_data,
    input  logic       prog_en,
    input  logic [3:0] gfx_en,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       LHBL_dly,
    output logic       LVBL_dly
);

    logic [7:0]           prom [0:31];
    logic [4:0]           pal_idx;
    logic [7:0]           pal_dat;
    logic [BLANK_DLY-1:0] hbl_sr;
    logic [BLANK_DLY-1:0] vbl_sr;
    logic [3:0]           scr_eff;
    logic [3:0]           obj_eff;
    logic                 sel_obj;
    logic                 blank_ok;

    always_comb begin
        scr_eff  = gfx_en[0] ? scr_pxl : 4'd0;
        obj_eff  = gfx_en[3] ? obj_pxl : 4'd0;
        sel_obj  = (obj_eff != 4'd0) && !(scr_prio && (scr_eff != 4'd0));
        blank_ok = hbl_sr[BLANK_DLY-1] & vbl_sr[BLANK_DLY-1];
    end

    // Download port is independent of the pixel enable and never reset.
    always_ff @(posedge clk) begin
        if (prog_en) begin
            prom[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pal_idx  <= 5'd0;
            pal_dat  <= 8'd0;
            hbl_sr   <= '0;
            vbl_sr   <= '0;
            red      <= 4'd0;
            green    <= 4'd0;
            blue     <= 4'd0;
            LHBL_dly <= 1'b0;
            LVBL_dly <= 1'b0;
        end else if (pxl_cen) begin
            pal_idx <= sel_obj ? {1'b1, obj_eff} : {1'b0, scr_eff};
            // Same-clk PROM writes land after this read, so the old byte is seen.
            pal_dat <= prom[pal_idx];
            for (int i = BLANK_DLY - 1; i > 0; i--) begin
                hbl_sr[i] <= hbl_sr[i-1];
                vbl_sr[i] <= vbl_sr[i-1];
            end
            hbl_sr[0] <= LHBL;
            vbl_sr[0] <= LVBL;
            LHBL_dly  <= hbl_sr[BLANK_DLY-1];
            LVBL_dly  <= vbl_sr[BLANK_DLY-1];
            if (blank_ok) begin
                red   <= {pal_dat[7:5], pal_dat[7]};
                green <= {pal_dat[4:2], pal_dat[4]};
                blue  <= {pal_dat[1:0], pal_dat[1:0]};
            end else begin
                red   <= 4'd0;
                green <= 4'd0;
                blue  <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_jtkicker_colmix.sv
// Directed plus randomized checks of jtkicker_colmix against a pixel-level reference model.
module tb_jtkicker_colmix;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pxl_cen = 1'b0;
    logic [3:0] scr_pxl = 4'd0;
    logic       scr_prio = 1'b0;
    logic [3:0] obj_pxl = 4'd0;
    logic       LHBL = 1'b1;
    logic       LVBL = 1'b1;
    logic [4:0] prog_addr = 5'd0;
    logic [7:0] prog_data = 8'd0;
    logic       prog_en = 1'b0;
    logic [3:0] gfx_en = 4'b1001;
    logic [3:0] red, green, blue;
    logic       LHBL_dly, LVBL_dly;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mprom [0:31];
    logic [13:0] expq [$];
    logic [13:0] last_exp = 14'd0;
    logic [13:0] outs;

    jtkicker_colmix #(.BLANK_DLY(2)) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
        .scr_pxl(scr_pxl), .scr_prio(scr_prio), .obj_pxl(obj_pxl),
        .LHBL(LHBL), .LVBL(LVBL),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_en(prog_en),
        .gfx_en(gfx_en),
        .red(red), .green(green), .blue(blue),
        .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
    );

    always #5 clk = ~clk;

    assign outs = {red, green, blue, LHBL_dly, LVBL_dly};

    // Expected {red,green,blue,LHBL_dly,LVBL_dly} for one presented pixel.
    function automatic logic [13:0] model(input int s, input int p, input int o,
                                          input logic [3:0] ge, input int hb, input int vb);
        int se, oe, idx, d, r, g, b;
        se = ge[0] ? s : 0;
        oe = ge[3] ? o : 0;
        if (oe != 0 && !(p != 0 && se != 0)) idx = 16 + oe;
        else                                 idx = se;
        d = int'(mprom[idx]);
        r = d / 32;
        g = (d / 4) % 8;
        b = d % 4;
        if (hb != 0 && vb != 0)
            return {4'(r * 2 + r / 4), 4'(g * 2 + g / 4), 4'(b * 5), 1'b1, 1'b1};
        return {12'd0, 1'(hb), 1'(vb)};
    endfunction

    task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        pxl_cen = 1'b1;
        prog_en = 1'b0;
        @(negedge clk);
        chk(tag, outs, 14'd0);
        rst = 1'b0;
        pxl_cen = 1'b0;
        expq = {};
        expq.push_back(14'd0);
        expq.push_back(14'd0);
        last_exp = 14'd0;
    endtask

    task automatic prog(input logic [4:0] a, input logic [7:0] d);
        prog_en = 1'b1;
        prog_addr = a;
        prog_data = d;
        mprom[a] = d;
        @(negedge clk);
        prog_en = 1'b0;
    endtask

    // Present one pixel for one pxl_cen; optional PROM write on the same clk.
    task automatic pix(input string tag, input logic [3:0] s, input logic p, input logic [3:0] o,
                       input logic hb, input logic vb, input bit wr, input logic [4:0] wa,
                       input logic [7:0] wd, input bit use_k, input logic [13:0] k);
        scr_pxl = s; scr_prio = p; obj_pxl = o; LHBL = hb; LVBL = vb;
        prog_en = wr; prog_addr = wa; prog_data = wd;
        if (wr) mprom[wa] = wd;
        expq.push_back(use_k ? k : model(int'(s), int'(p), int'(o), gfx_en, int'(hb), int'(vb)));
        pxl_cen = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0;
        prog_en = 1'b0;
        last_exp = expq.pop_front();
        chk(tag, outs, last_exp);
    endtask

    task automatic px(input string tag, input logic [3:0] s, input logic p, input logic [3:0] o);
        pix(tag, s, p, o, 1'b1, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0, 14'd0);
    endtask

    task automatic pxk(input string tag, input logic [3:0] s, input logic p, input logic [3:0] o,
                       input logic [13:0] k);
        pix(tag, s, p, o, 1'b1, 1'b1, 1'b0, 5'd0, 8'd0, 1'b1, k);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            scr_pxl = 4'($urandom);
            obj_pxl = 4'($urandom);
            LHBL = 1'($urandom);
            @(negedge clk);
            chk("hold", outs, last_exp);
        end
    endtask

    initial begin
        @(negedge clk);
        do_reset("reset");
        for (int i = 0; i < 32; i++) prog(5'(i), 8'($urandom));
        prog(5'h00, 8'h03);
        prog(5'h03, 8'hE0);
        prog(5'h15, 8'h1C);
        prog(5'h06, 8'hB6);
        prog(5'h07, 8'h49);

        // Priority, transparency, expansion
        pxk("prio0_sprite", 4'd3, 1'b0, 4'd5, {4'h0, 4'hF, 4'h0, 2'b11});
        pxk("prio1_scroll", 4'd3, 1'b1, 4'd5, {4'hF, 4'h0, 4'h0, 2'b11});
        pxk("prio1_transp", 4'd0, 1'b1, 4'd5, {4'h0, 4'hF, 4'h0, 2'b11});
        pxk("background",   4'd0, 1'b0, 4'd0, {4'h0, 4'h0, 4'hF, 2'b11});
        pxk("expand_b6",    4'd6, 1'b0, 4'd0, {4'hB, 4'hB, 4'hA, 2'b11});
        pxk("expand_49",    4'd7, 1'b0, 4'd0, {4'h4, 4'h4, 4'h5, 2'b11});

        // One-pixel blank with a colour pulse, irregular pxl_cen spacing
        px("pre_blank", 4'd7, 1'b0, 4'd0);
        idle(1);
        pix("blank_pulse", 4'd6, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 1'b1, {12'd0, 2'b01});
        idle(3);
        pxk("post_blank", 4'd7, 1'b0, 4'd0, {4'h4, 4'h4, 4'h5, 2'b11});
        idle(2);
        px("post_blank2", 4'd7, 1'b0, 4'd0);
        pix("vblank", 4'd6, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 8'd0, 1'b1, {12'd0, 2'b10});
        px("post_vblank", 4'd6, 1'b0, 4'd0);

        // Layer enables
        gfx_en = 4'b0001;
        pxk("gfx_scr_only", 4'd3, 1'b0, 4'd5, {4'hF, 4'h0, 4'h0, 2'b11});
        gfx_en = 4'b0000;
        pxk("gfx_off",      4'd3, 1'b1, 4'd5, {4'h0, 4'h0, 4'hF, 2'b11});
        pxk("gfx_off2",     4'd6, 1'b0, 4'd7, {4'h0, 4'h0, 4'hF, 2'b11});
        gfx_en = 4'b1001;

        // PROM rewrite on the same clk as a pixel reading entry 3
        pxk("rewrite_old", 4'd3, 1'b1, 4'd0, {4'hF, 4'h0, 4'h0, 2'b11});
        pix("rewrite_new", 4'd3, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 5'd3, 8'h49, 1'b1,
            {4'h4, 4'h4, 4'h5, 2'b11});
        pxk("rewrite_new2", 4'd3, 1'b0, 4'd0, {4'h4, 4'h4, 4'h5, 2'b11});

        // Mid-line reset
        px("pre_rst", 4'd6, 1'b0, 4'd0);
        px("pre_rst2", 4'd7, 1'b0, 4'd0);
        do_reset("reset_midline");
        for (int i = 0; i < 4; i++) px("post_rst", 4'd6, 1'b0, 4'd0);

        // Randomized pixels with occasional gaps and same-clk downloads
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0:       gfx_en = 4'b0001;
                1:       gfx_en = 4'b1000;
                2:       gfx_en = 4'($urandom);
                default: gfx_en = 4'b1001;
            endcase
            pix("random", 4'($urandom), 1'($urandom), 4'($urandom),
                1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 7) != 0),
                $urandom_range(0, 7) == 0, 5'($urandom), 8'($urandom), 1'b0, 14'd0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
